// File: rtl/opcode_seq.sv
// Fetch/decode/execute sequencer: fetches into IR, exposes opcode/ind/addr, and runs a 4-bit timing counter.
// Optional macro SC_WDOG_EN turns sc==15 in EXEC into a sticky err and a HALT.
module opcode_seq #(
  parameter int PC_W = 12,
  parameter int IR_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [IR_W-1:0] mem_data,
  output logic [2:0]      opcode,
  output logic            ind,
  output logic [PC_W-1:0] addr,
  output logic            dec_valid,
  output logic [3:0]      sc,
  input  logic            exec_done,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_in,
  input  logic            halt,
  output logic            err
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [IR_W-1:0]   r_ir;
  logic [3:0]        r_sc;
  logic              w_ir_load;
  logic              w_pc_branch;
  logic              w_wdog_trip;
  logic              w_sc_clr;

`ifdef SC_WDOG_EN
  logic r_err;

  assign w_wdog_trip = (r_state == S_EXEC) && !exec_done && (r_sc == 4'hF);
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_wdog_trip)
      r_err <= 1'b1;
  end
`else
  assign w_wdog_trip = 1'b0;
  assign err         = 1'b0;
`endif

  // IR layout: [PC_W+3] indirect, [PC_W+2:PC_W] opcode, [PC_W-1:0] operand address.
  assign ind      = r_ir[PC_W+3];
  assign opcode   = r_ir[PC_W+2:PC_W];
  assign addr     = r_ir[PC_W-1:0];
  assign mem_addr = r_pc;
  assign sc       = r_sc;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_HALT;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    dec_valid   = 1'b0;
    w_ir_load   = 1'b0;
    w_pc_branch = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_ir_load   = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        dec_valid   = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        // A branch is taken on completion even when halt wins the state transition.
        w_pc_branch = exec_done && pc_load;
        if (halt || w_wdog_trip)
          w_state_nxt = S_HALT;
        else if (exec_done)
          w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (start)
          w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  // sc reads 0 on the first FETCH cycle and throughout HALT.
  assign w_sc_clr = (w_state_nxt == S_HALT) ||
                    ((w_state_nxt == S_FETCH) && (r_state != S_FETCH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_ir <= '0;
      r_sc <= 4'd0;
    end else begin
      if (w_ir_load) begin
        r_ir <= mem_data;
        r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
      end else if (w_pc_branch) begin
        r_pc <= pc_in;
      end
      r_sc <= w_sc_clr ? 4'd0 : r_sc + 4'd1;
    end
  end

endmodule

// File: doc/opcode_seq.md
OPCODE_SEQ -- requirements
Module: opcode_seq

Interface
REQ-001 Parameter PC_W, default 12, is the program-counter and memory-address width.
REQ-002 Parameter IR_W, default 16, is the instruction-register width; IR_W SHALL equal PC_W+4.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle pulse that leaves HALT.
REQ-006 mem_req  output  1  instruction fetch request.
REQ-007 mem_addr  output  PC_W  fetch address; SHALL equal pc.
REQ-008 mem_ack  input  1  fetch data valid.
REQ-009 mem_data  input  IR_W  fetched instruction word.
REQ-010 opcode  output  3  IR[14:12], the select input to the downstream 3-to-8 opcode decoder.
REQ-011 ind  output  1  IR[15], the indirect-address bit.
REQ-012 addr  output  PC_W  IR[PC_W-1:0], the operand address.
REQ-013 dec_valid  output  1  high for exactly one cycle while the opcode is being decoded.
REQ-014 sc  output  4  sequence-counter (timing) value.
REQ-015 exec_done  input  1  the execute unit has finished the current instruction.
REQ-016 pc_load / pc_in  input  1 / PC_W  branch request and branch target.
REQ-017 halt  input  1  halt request from the execute unit.
REQ-018 err  output  1  sticky watchdog error (see Configuration).

Function
REQ-019 States: FETCH, DECODE, EXEC, HALT; state SHALL be registered.
REQ-020 opcode, ind, and addr SHALL be driven combinationally from the registered IR, with no extra latency.
REQ-021 FETCH: mem_req=1; on mem_ack the block SHALL load IR<=mem_data, set pc<=pc+1 (mod 2^PC_W, so all-ones wraps to 0), and go to DECODE next cycle.
REQ-022 FETCH without mem_ack: the block SHALL hold pc, IR, and mem_req=1 indefinitely.
REQ-023 DECODE: dec_valid=1 and mem_req=0; the block SHALL go unconditionally to EXEC after one cycle.
REQ-024 EXEC: the block SHALL wait for exec_done; on exec_done it SHALL go to FETCH.
REQ-025 pc_load SHALL set pc<=pc_in only when sampled with exec_done in EXEC; otherwise pc_load SHALL be ignored.
REQ-026 halt in EXEC SHALL go to HALT; halt together with exec_done SHALL go to HALT (halt wins) and pc_load SHALL still apply.
REQ-027 HALT: mem_req=0 and dec_valid=0; a start pulse SHALL go to FETCH next cycle; start SHALL be ignored in every other state.
REQ-028 mem_ack outside FETCH SHALL be ignored; IR and pc are unchanged.
REQ-029 sc SHALL clear to 0 on every entry to FETCH and in HALT, and SHALL increment by 1 on every other cycle.
REQ-030 sc wrap at 15 SHALL follow REQ-036/REQ-037.
REQ-031 Fetch-to-decode latency: dec_valid SHALL assert exactly one cycle after the mem_ack cycle.

Reset
REQ-032 rst_n=0 at a clock edge SHALL set state=HALT, pc=0, IR=0, sc=0, and err=0.
REQ-033 While reset is in effect and afterwards until start, mem_req=0 and dec_valid=0.
REQ-034 Reset SHALL take priority over all inputs.
REQ-035 Reset mid-FETCH SHALL drop mem_req the following cycle, and a concurrent mem_ack SHALL be discarded.

Configuration
REQ-036 With macro SC_WDOG_EN defined: if sc==15 in EXEC with no exec_done, the block SHALL set err<=1 (sticky until reset) and go to HALT next cycle.
REQ-037 Without SC_WDOG_EN: sc SHALL wrap 15->0, err SHALL be constant 0, and EXEC SHALL wait unbounded.

Verification
REQ-038 Reset then start, mem_data=16'hB123 with ack at the first FETCH cycle -> dec_valid one cycle later; opcode=3'b011, ind=1, addr=12'h123, pc=1.
REQ-039 pc=12'hFFF, fetch acked -> pc=12'h000 after the fetch.
REQ-040 EXEC with exec_done=1, pc_load=1, pc_in=12'h040 -> next state FETCH, mem_addr=12'h040, sc=0.
REQ-041 EXEC with halt=1 and exec_done=1 in the same cycle -> state HALT, mem_req=0; start -> FETCH the next cycle.
REQ-042 Stall in EXEC for 20 cycles -> with SC_WDOG_EN: err=1 and HALT once sc==15; without it: sc wraps to 0, err=0, and still EXEC.
REQ-043 rst_n=0 while in FETCH with mem_ack=1 -> IR stays 0, pc=0, state HALT, mem_req=0 the next cycle.
